// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] HALT_WORD = 32'h0;

    // Opcodes shared with the decoder and the bench
    localparam logic [5:0]  J         = 6'b000010;
    localparam logic [5:0]  BEQ       = 6'b000100;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational sequential, branch and jump target generation.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import fetch_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic [W-1:0] pc,
    input  logic [15:0]  branch_offset,
    input  logic [25:0]  jump_index,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] branch_target,
    output logic [W-1:0] jump_target
);

    logic [W-1:0] w_branch_disp;

    // Word offset sign-extended and scaled to bytes
    assign w_branch_disp = {{(W-18){branch_offset[15]}}, branch_offset, 2'b00};

    assign pc_plus4      = pc + W'(4);
    assign branch_target = pc_plus4 + w_branch_disp;
    assign jump_target   = {pc_plus4[W-1:28], jump_index, 2'b00};

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register, next-PC selection, halt/fault detection and
//               retired-instruction counter feeding a synchronous imem.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              SIZE      = 8,
    parameter logic [4*SIZE-1:0] RESET_PC = '0,
    parameter int              MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic [4*SIZE-1:0] imem_instr,
    output logic [4*SIZE-1:0] imem_adr,
    output logic [4*SIZE-1:0] pc,
    output logic [4*SIZE-1:0] instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       instr_count
);

    localparam int              c_w         = 4 * SIZE;
    localparam logic [c_w:0]    c_last_byte = (c_w+1)'(MEM_BYTES - 1);

    fetch_state_t   r_state;
    fetch_state_t   w_next_state;
    logic [c_w-1:0] r_pc;
    logic [c_w-1:0] w_next_pc;
    logic [31:0]    r_count;
    logic           w_count_en;

    logic [c_w-1:0] w_pc_plus4;
    logic [c_w-1:0] w_branch_target;
    logic [c_w-1:0] w_jump_target;
    logic [c_w-1:0] w_cand;
    logic           w_out_of_range;

    pc_target_calc #(
        .W (c_w)
    ) u_pc_target_calc (
        .pc            (r_pc),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .pc_plus4      (w_pc_plus4),
        .branch_target (w_branch_target),
        .jump_target   (w_jump_target)
    );

    assign w_cand = jump         ? w_jump_target   :
                    branch_taken ? w_branch_target :
                                   w_pc_plus4;

    // Extra bit keeps the last-byte check free of 32-bit wrap
    assign w_out_of_range = (({1'b0, w_cand} + (c_w+1)'(3)) > c_last_byte);

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_count_en   = 1'b0;
        case (r_state)
            BOOT: begin
                w_next_pc    = RESET_PC;
                w_next_state = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (imem_instr == HALT_WORD) begin
                        w_next_state = HALT;
                    end else begin
                        w_count_en = 1'b1;
                        if (w_out_of_range) begin
                            w_next_state = FAULT;
                        end else begin
                            w_next_pc = w_cand;
                        end
                    end
                end
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_count_en) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // The memory latches imem_adr on the same edge that loads pc
    assign imem_adr    = w_next_pc;
    assign pc          = r_pc;
    assign instr       = imem_instr;
    assign instr_valid = (r_state == RUN);
    assign halted      = (r_state == HALT);
    assign fault       = (r_state == FAULT);
    assign instr_count = r_count;

endmodule
`default_nettype wire
